// File: rtl/fixed_p_std_div_pipe.sv
// Multi-cycle unsigned fixed-point divider.
// Restoring shift-subtract, one quotient bit per cycle.
module fixed_p_std_div_pipe #(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             overflow,
  output logic             done
);

  localparam int N  = WIDTH + FRACT_WIDTH;
  localparam int CW = $clog2(N);

  if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_bad_width
    $error("WIDTH must equal INT_WIDTH + FRACT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [N-1:0]     r_dvd;
  logic [N-2:0]     r_quot;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_ovf;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [N-1:0]     w_quot_nxt;
  logic             w_last;
  logic             w_div0;

  // The top quotient bit comes straight from this cycle's compare,
  // so only N-1 bits need to be held between cycles.
  assign w_shift    = {r_rem, r_dvd[N-1]};
  assign w_ge       = w_shift >= {1'b0, r_div};
  assign w_rem_nxt  = w_ge ? (w_shift[WIDTH-1:0] - r_div)
                           : w_shift[WIDTH-1:0];
  assign w_quot_nxt = {r_quot, w_ge};
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_div0     = (r_div == '0);

  assign out_quotient  = r_q_out;
  assign out_remainder = r_r_out;
  assign overflow      = r_ovf;
  assign done          = (r_state == DONE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, N iterations, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (go) w_state_nxt = BUSY;
      BUSY:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (go) begin
        r_dvd  <= {left, {FRACT_WIDTH{1'b0}}};
        r_div  <= right;
        r_rem  <= '0;
        r_quot <= '0;
        r_cnt  <= '0;
      end
    end else if (r_state == BUSY) begin
      r_dvd  <= {r_dvd[N-2:0], 1'b0};
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt[N-2:0];
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        if (w_div0) begin
          r_q_out <= '1;
          r_r_out <= '0;
          r_ovf   <= 1'b1;
        end else begin
          r_q_out <= w_quot_nxt[WIDTH-1:0];
          r_r_out <= w_rem_nxt;
          r_ovf   <= |w_quot_nxt[N-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Bench for fixed_p_std_div_pipe, 8-bit Q4.4 configuration.
// Directed plan steps plus randomized ops against an arithmetic model.
module tb_fixed_p_std_div_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [7:0] left;
  logic [7:0] right;
  logic [7:0] out_quotient;
  logic [7:0] out_remainder;
  logic       overflow;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  fixed_p_std_div_pipe #(
    .WIDTH(8),
    .INT_WIDTH(4),
    .FRACT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .left(left),
    .right(right),
    .out_quotient(out_quotient),
    .out_remainder(out_remainder),
    .overflow(overflow),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((l * 16) / r) truncated to 8 bits.
  function automatic void model(input logic [7:0] l, input logic [7:0] r,
                                output logic [7:0] q,
                                output logic [7:0] rm,
                                output logic ov);
    int dd;
    int qf;
    if (r == 8'h00) begin
      q  = 8'hFF;
      rm = 8'h00;
      ov = 1'b1;
    end else begin
      dd = int'(l) * 16;
      qf = dd / int'(r);
      q  = 8'(qf);
      rm = 8'(dd % int'(r));
      ov = (qf > 255);
    end
  endfunction

  // One operation: go pulsed for one cycle (cycle 0), done expected
  // in cycle 13, then low again in cycle 14.
  task automatic op(input logic [7:0] l, input logic [7:0] r,
                    input bit scr, input logic [7:0] eq,
                    input logic [7:0] er, input logic eo,
                    input string tag);
    int c;
    @(negedge clk);
    go    = 1'b1;
    left  = l;
    right = r;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      go = 1'b0;
      if (scr && !done) begin
        left  = 8'($urandom);
        right = 8'($urandom);
      end
    end while (!done && c < 40);
    chk({tag, "_lat"}, c, 13);
    chk({tag, "_q"}, out_quotient, eq);
    chk({tag, "_r"}, out_remainder, er);
    chk({tag, "_ov"}, overflow, eo);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    logic [7:0] l, r, eq, er;
    logic       eo;
    int         c;
    bit         saw_done;

    reset = 1'b0;
    go    = 1'b0;
    left  = 8'h00;
    right = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_q", out_quotient, 8'h00);
    chk("rst_r", out_remainder, 8'h00);
    chk("rst_ov", overflow, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;

    op(8'h30, 8'h18, 1'b0, 8'h20, 8'h00, 1'b0, "basic");
    op(8'h10, 8'h30, 1'b0, 8'h05, 8'h10, 1'b0, "fract");

    repeat (3) @(negedge clk);
    chk("hold_q", out_quotient, 8'h05);
    chk("hold_r", out_remainder, 8'h10);

    op(8'hF0, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, "ovf");
    op(8'h55, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1, "div0");

    // Reset asserted in cycle 5 of an operation.
    @(negedge clk);
    go    = 1'b1;
    left  = 8'h30;
    right = 8'h18;
    repeat (5) begin
      @(negedge clk);
      go = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("midrst_q", out_quotient, 8'h00);
    chk("midrst_r", out_remainder, 8'h00);
    chk("midrst_ov", overflow, 0);
    chk("midrst_done", done, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    op(8'h30, 8'h18, 1'b0, 8'h20, 8'h00, 1'b0, "after_rst");

    // Operands scrambled every BUSY cycle.
    op(8'h30, 8'h18, 1'b1, 8'h20, 8'h00, 1'b0, "scramble");

    // go held high through done: second op accepted in cycle 14.
    @(negedge clk);
    go    = 1'b1;
    left  = 8'h30;
    right = 8'h18;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 40);
    chk("b2b_lat1", c, 13);
    chk("b2b_q1", out_quotient, 8'h20);
    left  = 8'h10;
    right = 8'h30;
    @(negedge clk);
    c++;
    chk("b2b_gap", done, 0);
    do begin
      @(negedge clk);
      c++;
      go = 1'b0;
    end while (!done && c < 60);
    chk("b2b_lat2", c, 27);
    chk("b2b_q2", out_quotient, 8'h05);
    chk("b2b_r2", out_remainder, 8'h10);
    chk("b2b_ov2", overflow, 0);
    @(negedge clk);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      l = 8'($urandom);
      r = (i % 8 == 7) ? 8'h00 : 8'($urandom);
      model(l, r, eq, er, eo);
      op(l, r, i[0], eq, er, eo, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
